// File: rtl/core_ras_pkg.sv
// Shared pipeline types for the branch predictor: target-type encoding,
// prediction and resolution records, and return-stack sizing.
package core_ras_pkg;

  localparam int BPU_RAS_DEPTH = 8;
  localparam int BPU_RAS_PTR_W = $clog2(BPU_RAS_DEPTH);
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_CALL = 2'd1,
    TGT_RET  = 2'd2,
    TGT_IMM  = 2'd3
  } tgt_type_e;

  typedef struct packed {
    logic                     valid;
    logic [31:0]              pc;
    tgt_type_e                target_type;
    logic [BPU_RAS_PTR_W-1:0] ras_ptr;
  } bpu_predict_t;

  typedef struct packed {
    logic                     miss;
    logic [31:0]              pc;
    tgt_type_e                true_target_type;
    logic [BPU_RAS_PTR_W-1:0] ras_ptr;
  } bpu_correct_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/core_ras.sv
// Return address stack: circular flop array pushed/popped by fetch-side
// predictions and repaired from the resolved branch record on a miss.
module core_ras
  import core_ras_pkg::*;
#(
  parameter int RAS_DEPTH = BPU_RAS_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pred_valid_i,
  input  logic [1:0]                   pred_target_type_i,
  input  logic [31:0]                  pred_pc_i,
  output logic [31:0]                  ras_top_o,
  output logic [$clog2(RAS_DEPTH)-1:0] ras_ptr_o,
  input  logic                         correct_valid_i,
  input  bpu_correct_t                 correct_i
);

  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  logic [RAS_PTR_W-1:0] r_ptr;
  logic [31:0]          r_stack [RAS_DEPTH];

  logic [RAS_PTR_W-1:0] w_ptr_nxt;
  logic                 w_wr_en;
  logic [RAS_PTR_W-1:0] w_wr_idx;
  logic [31:0]          w_wr_data;
  logic [RAS_PTR_W-1:0] w_corr_ptr;

  assign w_corr_ptr = RAS_PTR_W'(correct_i.ras_ptr);

  // A miss redirects fetch, so any same-cycle prediction is dropped.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_ptr + 1'b1;
    w_wr_data = pc_plus4(pred_pc_i);
    if (correct_valid_i && correct_i.miss) begin
      w_wr_idx  = w_corr_ptr + 1'b1;
      w_wr_data = pc_plus4(correct_i.pc);
      unique case (correct_i.true_target_type)
        TGT_CALL: begin
          w_wr_en   = 1'b1;
          w_ptr_nxt = w_corr_ptr + 1'b1;
        end
        TGT_RET: w_ptr_nxt = w_corr_ptr - 1'b1;
        default: w_ptr_nxt = w_corr_ptr;
      endcase
    end else if (pred_valid_i) begin
      unique case (tgt_type_e'(pred_target_type_i))
        TGT_CALL: begin
          w_wr_en   = 1'b1;
          w_ptr_nxt = r_ptr + 1'b1;
        end
        TGT_RET: w_ptr_nxt = r_ptr - 1'b1;
        default: w_ptr_nxt = r_ptr;
      endcase
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values; the
  // stack is a flop array (async read), so resetting each entry is legal here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_stack[i] <= RESET_PC;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_wr_en) r_stack[w_wr_idx] <= w_wr_data;
    end
  end

  assign ras_top_o = r_stack[r_ptr];
  assign ras_ptr_o = r_ptr;

endmodule

// File: tb/tb_core_ras.sv
// Directed bench for core_ras: stimulus pushes expected pointer/top into a
// scoreboard queue, a negedge monitor pops and compares.
module tb_core_ras;
  import core_ras_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pred_valid_i;
  logic [1:0]   pred_target_type_i;
  logic [31:0]  pred_pc_i;
  logic [31:0]  ras_top_o;
  logic [2:0]   ras_ptr_o;
  logic         correct_valid_i;
  bpu_correct_t correct_i;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  ptr;
    logic [31:0] top;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  core_ras #(.RAS_DEPTH(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pred_valid_i       (pred_valid_i),
    .pred_target_type_i (pred_target_type_i),
    .pred_pc_i          (pred_pc_i),
    .ras_top_o          (ras_top_o),
    .ras_ptr_o          (ras_ptr_o),
    .correct_valid_i    (correct_valid_i),
    .correct_i          (correct_i)
  );

  task automatic check(input string name, input exp_t act, input exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ptr=%0d top=%h, expected ptr=%0d top=%h",
               name, act.ptr, act.top, exp.ptr, exp.top);
    end
  endtask

  // Monitor: outputs are registered, so each negedge shows the state
  // produced by the preceding posedge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.ptr = ras_ptr_o;
      a.top = ras_top_o;
      check(n, a, e);
    end
  end

  task automatic step(input logic rst, input logic pv, input tgt_type_e pt,
                      input logic [31:0] ppc, input logic cv, input logic miss,
                      input tgt_type_e ct, input logic [31:0] cpc,
                      input logic [2:0] cptr, input logic [2:0] e_ptr,
                      input logic [31:0] e_top, input string name);
    exp_t e;
    rst_n                      = rst;
    pred_valid_i               = pv;
    pred_target_type_i         = pt;
    pred_pc_i                  = ppc;
    correct_valid_i            = cv;
    correct_i.miss             = miss;
    correct_i.true_target_type = ct;
    correct_i.pc               = cpc;
    correct_i.ras_ptr          = cptr;
    @(posedge clk);
    e.ptr = e_ptr;
    e.top = e_top;
    exp_q.push_back(e);
    name_q.push_back(name);
    #1;
  endtask

  task automatic pred(input tgt_type_e pt, input logic [31:0] ppc,
                      input logic [2:0] e_ptr, input logic [31:0] e_top,
                      input string name);
    step(1'b1, 1'b1, pt, ppc, 1'b0, 1'b0, TGT_NONE, 32'h0, 3'd0,
         e_ptr, e_top, name);
  endtask

  task automatic miss(input tgt_type_e ct, input logic [31:0] cpc,
                      input logic [2:0] cptr, input logic [2:0] e_ptr,
                      input logic [31:0] e_top, input string name);
    step(1'b1, 1'b0, TGT_NONE, 32'h0, 1'b1, 1'b1, ct, cpc, cptr,
         e_ptr, e_top, name);
  endtask

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0;
    pred_valid_i = 1'b0;
    pred_target_type_i = 2'd0;
    pred_pc_i = '0;
    correct_valid_i = 1'b0;
    correct_i = '0;

    step(1'b0, 1'b0, TGT_NONE, 32'h0, 1'b0, 1'b0, TGT_NONE, 32'h0, 3'd0,
         3'd0, 32'h1c00_0000, "reset");
    pred(TGT_CALL, 32'h1c00_0100, 3'd1, 32'h1c00_0104, "call");
    pred(TGT_RET,  32'h1c00_0200, 3'd0, 32'h1c00_0000, "return");
    step(1'b1, 1'b0, TGT_CALL, 32'h1c00_0300, 1'b0, 1'b0, TGT_NONE, 32'h0,
         3'd0, 3'd0, 32'h1c00_0000, "call_not_valid");
    pred(TGT_IMM,  32'h1c00_0400, 3'd0, 32'h1c00_0000, "pred_imm");
    pred(TGT_NONE, 32'h1c00_0500, 3'd0, 32'h1c00_0000, "pred_none");

    // Nine calls wrap the 8-entry stack; index 1 ends holding the 9th address.
    for (int i = 0; i < 9; i++) begin
      pc = 32'h1c00_1000 + 32'(i * 16);
      pred(TGT_CALL, pc, 3'((i + 1) % 8), pc + 32'd4, "call_seq");
    end
    pred(TGT_RET, 32'h0, 3'd0, 32'h1c00_1074, "ret_after_wrap");

    step(1'b1, 1'b1, TGT_RET, 32'h1c00_0600, 1'b1, 1'b1, TGT_CALL,
         32'h1c00_0200, 3'd2, 3'd3, 32'h1c00_0204, "miss_call_vs_pop");
    miss(TGT_RET, 32'h1c00_0700, 3'd0, 3'd7, 32'h1c00_1064, "miss_ret_wrap");
    step(1'b1, 1'b0, TGT_NONE, 32'h0, 1'b1, 1'b0, TGT_CALL, 32'h1c00_0800,
         3'd2, 3'd7, 32'h1c00_1064, "correct_no_miss");
    pred(TGT_CALL, 32'hffff_fffc, 3'd0, 32'h0000_0000, "pc4_wrap");
    miss(TGT_IMM,  32'h1c00_0900, 3'd5, 3'd5, 32'h1c00_1044, "miss_imm");
    miss(TGT_NONE, 32'h1c00_0a00, 3'd3, 3'd3, 32'h1c00_0204, "miss_none");

    step(1'b0, 1'b1, TGT_CALL, 32'h1c00_0b00, 1'b1, 1'b1, TGT_CALL,
         32'h1c00_0c00, 3'd4, 3'd0, 32'h1c00_0000, "reset_over_miss");
    miss(TGT_NONE, 32'h0, 3'd3, 3'd3, 32'h1c00_0000, "entry3_reset");
    miss(TGT_NONE, 32'h0, 3'd1, 3'd1, 32'h1c00_0000, "entry1_reset");

    pred_valid_i = 1'b0;
    correct_valid_i = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_ras.md
CORE_RAS -- requirements
Module: core_ras

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low, on ports clk and rst_n.
REQ-002 Parameter RAS_DEPTH, default 8, SHALL set the number of stack entries; a power of two, at least 4.
REQ-003 Derived constant RAS_PTR_W, equal to log2(RAS_DEPTH), SHALL set the stack pointer width.
REQ-004 Port clk  input  1  SHALL be the clock.
REQ-005 Port rst_n  input  1  SHALL be the synchronous active-low reset.
REQ-006 Port pred_valid_i  input  1  SHALL flag a fetch-side branch prediction this cycle.
REQ-007 Port pred_target_type_i  input  2  SHALL give the predicted target type: 0 none, 1 call, 2 return, 3 immediate.
REQ-008 Port pred_pc_i  input  32  SHALL carry the PC of the predicted branch.
REQ-009 Port ras_top_o  output  32  SHALL present the return address at the top of the stack, used as the return target.
REQ-010 Port ras_ptr_o  output  RAS_PTR_W  SHALL present the current pointer; fetch stores it in bpu_predict_t.ras_ptr.
REQ-011 Port correct_valid_i  input  1  SHALL flag that correct_i is valid this cycle.
REQ-012 Port correct_i  input  bpu_correct_t  SHALL carry the branch-resolution record; fields used are miss, pc, true_target_type and ras_ptr.

Function
REQ-013 The stack SHALL be a circular array of RAS_DEPTH 32-bit entries; ptr indexes the top entry.
REQ-014 ras_top_o SHALL be the combinational read of stack[ptr]; ras_ptr_o SHALL equal ptr.
REQ-015 Predict push: when pred_valid_i is high and type is call, the block SHALL on the next edge write pred_pc_i+4 to stack[ptr+1] and set ptr to ptr+1.
REQ-016 Predict pop: when pred_valid_i is high and type is return, the block SHALL on the next edge set ptr to ptr-1, with no write.
REQ-017 Types none and immediate, or pred_valid_i low, SHALL leave ptr and the stack unchanged.
REQ-018 Pointer arithmetic SHALL be modulo RAS_DEPTH: overflow overwrites the oldest entry; underflow wraps and returns stale contents, with no error signalled.
REQ-019 PC+4 SHALL be a 32-bit add with wrap; carry is discarded.
REQ-020 Recovery: when correct_valid_i and correct_i.miss are both high, ptr SHALL be rebuilt from correct_i.ras_ptr, which is the pointer before that branch executed:
- call: write correct_i.pc+4 to stack[ras_ptr+1]; ptr is ras_ptr+1.
- return: ptr is ras_ptr-1.
- none or immediate: ptr is ras_ptr.
REQ-021 Recovery SHALL take priority over a same-cycle prediction push or pop; the prediction is discarded because fetch is being redirected.
REQ-022 correct_valid_i high with miss low SHALL have no effect.
REQ-023 Latency: every update SHALL become visible on ras_top_o and ras_ptr_o in the cycle after the triggering edge; there SHALL be no combinational path from any input to either output within the same cycle.
REQ-024 Entries overwritten by wrong-path pushes SHALL NOT be restored; only the pointer and the single corrected entry are repaired.

Reset
REQ-025 When rst_n is low at a clock edge, ptr SHALL become 0 and every entry SHALL become 32'h1c000000, the reset PC.
REQ-026 Reset SHALL dominate recovery and prediction in the same cycle, and SHALL abort any update in progress.
REQ-027 In the cycle after reset, outputs SHALL be ras_top_o = 32'h1c000000 and ras_ptr_o = 0.

Structure
REQ-028 bpu_correct_t, bpu_predict_t and the target-type constants (none, call, return, immediate) SHALL live in the shared pipeline package and header; ras_ptr width SHALL derive from RAS_DEPTH there.
REQ-029 The block SHALL be a single module with a flop-array stack and no sub-module; the stack SHALL NOT be inferred as RAM, because reads are asynchronous.

Verification
REQ-030 Reset, then call at pc 0x1c000100 -> next cycle ras_ptr_o=1, ras_top_o=0x1c000104.
REQ-031 That call followed by a return prediction -> ras_ptr_o=0, ras_top_o=0x1c000000.
REQ-032 9 consecutive calls with RAS_DEPTH=8 -> ras_ptr_o=1, and stack[1] holds the 9th return address (wrap-around).
REQ-033 Miss with ras_ptr=2, type call, pc 0x1c000200, plus a same-cycle predicted return -> ras_ptr_o=3, ras_top_o=0x1c000204; the pop is ignored.
REQ-034 Miss with ras_ptr=0, type return -> ras_ptr_o=7 (underflow wrap); miss low with valid high -> no change.
REQ-035 rst_n low during a miss cycle -> ras_ptr_o=0, ras_top_o=0x1c000000.
